// File: rtl/past_pkg.sv
// Shared types and derived-width helpers for the sampled-history controller.
package past_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        FULL   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    function automatic int sel_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/past_tap_shreg.sv
// WIDTH x DEPTH history shift register; tap 0 holds the newest sample.
module past_tap_shreg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         shift_en,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             d,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    logic [DEPTH-1:0][WIDTH-1:0] taps_q;

    // Clear wins over shift so a flush never lets a sample slip in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps_q <= '0;
        end else if (clear) begin
            taps_q <= '0;
        end else if (shift_en) begin
            taps_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign taps = taps_q;

endmodule

// File: rtl/past_window_ctrl.sv
// Sequencer for a multi-tap $past history: fill tracking, freeze/flush and a
// sticky mismatch checker on the selected tap.
module past_window_ctrl
    import past_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int SEL_W = sel_width(DEPTH),
    parameter int CNT_W = cnt_width(DEPTH)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             flush,
    input  logic             freeze_req,
    output logic             freeze_ack,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] past_q,
    output logic             past_valid,
    output logic [CNT_W-1:0] fill_cnt,
    input  logic             chk_en,
    input  logic [WIDTH-1:0] exp,
    output logic             err,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_d;
    logic                        err_q;
    logic                        ack_q;
    logic                        shift_en;
    logic                        mismatch;
    logic [DEPTH-1:0][WIDTH-1:0] taps;

    // Shifting is allowed in IDLE (first sample) and in FILL/FULL unless a
    // freeze or flush takes priority this edge.
    always_comb begin
        shift_en = 1'b0;
        if (!flush && en) begin
            if (state_q == IDLE) begin
                shift_en = 1'b1;
            end else if ((state_q == FILL || state_q == FULL) && !freeze_req) begin
                shift_en = 1'b1;
            end
        end
    end

    assign cnt_d = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + CNT_W'(1);

    past_tap_shreg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_shreg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clear    (flush),
        .d        (d),
        .taps     (taps)
    );

    // Selects beyond the last tap read as zero rather than aliasing.
    always_comb begin
        past_q = '0;
        if (int'(sel) < DEPTH) begin
            past_q = taps[sel];
        end
    end

    assign past_valid = (int'(cnt_q) > int'(sel));
    assign mismatch   = chk_en && past_valid && (past_q != exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            if (mismatch) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= FILL;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                FILL, FULL: begin
                    if (freeze_req) begin
                        state_q <= FROZEN;
                        ack_q   <= 1'b1;
                    end else if (en) begin
                        cnt_q   <= cnt_d;
                        state_q <= (cnt_d == DEPTH_C) ? FULL : FILL;
                    end
                end
                FROZEN: begin
                    if (!freeze_req) begin
                        state_q <= (cnt_q == DEPTH_C) ? FULL : FILL;
                        ack_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freeze_ack = ack_q;
    assign fill_cnt   = cnt_q;
    assign err        = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_past_window_ctrl.sv
// Scoreboard bench for past_window_ctrl against a queue-based history model.
module tb_past_window_ctrl;

    localparam int WIDTH = 1;
    localparam int DEPTH = 4;
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] dIn;
    logic             flush;
    logic             freezeReq;
    logic             freezeAck;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] pastQ;
    logic             pastValid;
    logic [CNT_W-1:0] fillCnt;
    logic             chkEn;
    logic [WIDTH-1:0] expVal;
    logic             err;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               st;
        int               fill;
        logic             err;
        logic             ack;
        logic [WIDTH-1:0] pq;
        logic             pv;
    } expect_t;

    expect_t          sbQ[$];
    logic [WIDTH-1:0] mHist[$];
    int               mFill;
    int               mMode;
    logic             mErr;

    past_window_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .d          (dIn),
        .flush      (flush),
        .freeze_req (freezeReq),
        .freeze_ack (freezeAck),
        .sel        (sel),
        .past_q     (pastQ),
        .past_valid (pastValid),
        .fill_cnt   (fillCnt),
        .chk_en     (chkEn),
        .exp        (expVal),
        .err        (err),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mHist.delete();
        for (int i = 0; i < DEPTH; i++) mHist.push_back('0);
        mFill = 0;
        mMode = 0;
        mErr  = 1'b0;
    endtask

    function automatic expect_t modelView(input int s);
        expect_t e;
        e.st   = mMode;
        e.fill = mFill;
        e.err  = mErr;
        e.ack  = (mMode == 3);
        e.pq   = (s < DEPTH) ? mHist[s] : '0;
        e.pv   = (s < DEPTH) && (mFill > s);
        return e;
    endfunction

    task automatic modelShift(input logic [WIDTH-1:0] v);
        mHist.push_front(v);
        void'(mHist.pop_back());
        if (mFill < DEPTH) mFill++;
    endtask

    task automatic modelStep(input logic f, input logic fr, input logic e,
                             input logic [WIDTH-1:0] dv, input int s,
                             input logic c, input logic [WIDTH-1:0] ev);
        expect_t pre;
        pre = modelView(s);
        if (f) begin
            modelReset();
        end else begin
            if (c && pre.pv && (pre.pq != ev)) mErr = 1'b1;
            case (mMode)
                0: if (e) begin modelShift(dv); mMode = 1; end
                1, 2: begin
                    if (fr) mMode = 3;
                    else if (e) begin
                        modelShift(dv);
                        mMode = (mFill == DEPTH) ? 2 : 1;
                    end
                end
                default: if (!fr) mMode = (mFill == DEPTH) ? 2 : 1;
            endcase
        end
    endtask

    // One clock of stimulus: drive away from the edge, predict, enqueue.
    task automatic applyStimulus(input logic f, input logic fr, input logic e,
                                 input logic [WIDTH-1:0] dv, input int s,
                                 input logic c, input logic [WIDTH-1:0] ev);
        @(negedge clk);
        flush     = f;
        freezeReq = fr;
        en        = e;
        dIn       = dv;
        sel       = SEL_W'(s);
        chkEn     = c;
        expVal    = ev;
        modelStep(f, fr, e, dv, s, c, ev);
        sbQ.push_back(modelView(s));
    endtask

    task automatic checkOutput(input expect_t e, input string tag);
        compare({tag, "_state"}, int'(state), e.st);
        compare({tag, "_fill"}, int'(fillCnt), e.fill);
        compare({tag, "_err"}, int'(err), int'(e.err));
        compare({tag, "_ack"}, int'(freezeAck), int'(e.ack));
        compare({tag, "_pastq"}, int'(pastQ), int'(e.pq));
        compare({tag, "_pvalid"}, int'(pastValid), int'(e.pv));
    endtask

    // Monitor: every edge the DUT presents a new registered state; compare it
    // against whatever the stimulus predicted for that edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) checkOutput(sbQ.pop_front(), "edge");
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; dIn = '0; flush = 1'b0; freezeReq = 1'b0;
        sel = '0; chkEn = 1'b0; expVal = '0;
        modelReset();
        #23;
        checkOutput(modelView(0), "reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with 1,0,1,1 then sweep the taps without shifting
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        for (int s = 0; s < DEPTH; s++) applyStimulus(0, 0, 0, 0, s, 0, 0);
        compare("fill_taps", int'(mHist[0]) * 8 + int'(mHist[1]) * 4 + int'(mHist[2]) * 2 + int'(mHist[3]), 13);

        // Partial fill and an ignored check on an invalid tap
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 2, 1, 0);
        applyStimulus(0, 0, 0, 0, 2, 0, 0);

        // Freeze from FULL while en and d keep toggling, then release
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 1, WIDTH'(i & 1), 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, WIDTH'(i & 1), i % DEPTH, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Sticky error on a mismatching tap, cleared only by flush
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);

        // Flush beats freeze, shift and a mismatching check on the same edge
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Async reset mid-FILL, observed before the next edge
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0, 0);
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput(modelView(1), "async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(0, 0, 1, WIDTH'(~i & 1), i % DEPTH, 0, 0);

        // Randomised traffic with freeze held in bursts
        begin
            logic fr;
            fr = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 7) == 0) fr = ~fr;
                applyStimulus($urandom_range(0, 29) == 0, fr,
                              $urandom_range(0, 3) != 0,
                              WIDTH'($urandom), $urandom_range(0, DEPTH - 1),
                              $urandom_range(0, 3) == 0, WIDTH'($urandom));
            end
        end

        @(negedge clk);
        @(negedge clk);
        compare("scoreboard_drained", sbQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
